// File: rtl/midi_gate_controller_if.sv
// Byte-stream input and voice-control output bundle between the UART receiver,
// the MIDI gate controller and the voice (adsr envelope + oscillator).
interface midi_gate_controller_if;
   logic [3:0] channel;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       gate;
   logic [6:0] note;
   logic [6:0] velocity;
   logic       note_on;

   modport master (
      output channel, rx_data, rx_valid,
      input  gate, note, velocity, note_on
   );

   modport slave (
      input  channel, rx_data, rx_valid,
      output gate, note, velocity, note_on
   );
endinterface

// File: rtl/midi_gate_controller.sv
// Monophonic MIDI note-on/note-off parser driving the adsr gate, note and velocity,
// with running status, velocity-0 note-off, channel filtering and optional retrigger.
module midi_gate_controller #(
   parameter bit RETRIGGER = 1'b1,
   parameter bit OMNI      = 1'b0
) (
   input  logic                          clock,
   input  logic                          reset,
   midi_gate_controller_if.slave         bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_D1 = 2'd1,
      WAIT_D2 = 2'd2
   } state_t;

   state_t     state;
   logic       status_on;
   logic [6:0] pending_note;
   logic       gate_q;
   logic       retrig_low;
   logic [6:0] note_q;
   logic [6:0] velocity_q;
   logic       note_on_q;

   logic       is_status;
   logic       is_realtime;
   logic       is_voice;
   logic       chan_match;
   logic       sounding;

   assign is_status   = bus.rx_data[7];
   assign is_realtime = (bus.rx_data[7:3] == 5'b11111);
   assign is_voice    = (bus.rx_data[7:5] == 3'b100);
   assign chan_match  = OMNI || (bus.rx_data[3:0] == bus.channel);
   // A retrigger low cycle still counts as a held note for note-off and legato purposes.
   assign sounding    = gate_q || retrig_low;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         status_on    <= 1'b0;
         pending_note <= 7'd0;
         gate_q       <= 1'b0;
         retrig_low   <= 1'b0;
         note_q       <= 7'd0;
         velocity_q   <= 7'd0;
         note_on_q    <= 1'b0;
      end else begin
         note_on_q <= 1'b0;
         if (retrig_low) begin
            gate_q     <= 1'b1;
            retrig_low <= 1'b0;
         end

         if (bus.rx_valid) begin
            if (is_status) begin
               if (is_realtime) begin
                  // Real-time bytes may interleave anywhere and leave parsing untouched.
               end else if (is_voice && chan_match) begin
                  status_on <= bus.rx_data[4];
                  state     <= WAIT_D1;
               end else begin
                  status_on <= 1'b0;
                  state     <= IDLE;
               end
            end else begin
               case (state)
                  WAIT_D1: begin
                     pending_note <= bus.rx_data[6:0];
                     state        <= WAIT_D2;
                  end
                  WAIT_D2: begin
                     state <= WAIT_D1;
                     if (status_on && (bus.rx_data[6:0] != 7'd0)) begin
                        note_q     <= pending_note;
                        velocity_q <= bus.rx_data[6:0];
                        note_on_q  <= 1'b1;
                        if (RETRIGGER && sounding) begin
                           gate_q     <= 1'b0;
                           retrig_low <= 1'b1;
                        end else begin
                           gate_q     <= 1'b1;
                           retrig_low <= 1'b0;
                        end
                     end else if (sounding && (pending_note == note_q)) begin
                        // Release keeps note and velocity so the envelope tail uses them.
                        gate_q     <= 1'b0;
                        retrig_low <= 1'b0;
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end
      end
   end

   assign bus.gate     = gate_q;
   assign bus.note     = note_q;
   assign bus.velocity = velocity_q;
   assign bus.note_on  = note_on_q;

endmodule
